gate_bist_checker: RTL

// - Synthesizable self-test engine for a 2-input combinational gate (NOR by default).
// - Drives the four input vectors {A,B} = 00,01,10,11 in order and waits a settle window.
// - Samples the gate output Y and compares it against a parameterized truth table.
// - Reports pass/fail and the first failing vector. Sits beside the gate under test for in-system checking.

---
 rtl/gate_bist_checker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/gate_bist_checker.sv
// rtl/gate_bist_checker.sv - self-test engine for a 2-input gate; optional GATE_BIST_ERRCNT_EN adds err_cnt
module gate_bist_checker #(
    parameter logic [3:0] TRUTH_TABLE   = 4'b0001,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [1:0] fail_vec,
`ifdef GATE_BIST_ERRCNT_EN
    output logic [2:0] err_cnt,
`endif
    output logic       fail_y
);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FINISH} state_t;

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pass_q, pass_d;
    logic [1:0] fv_q, fv_d;
    logic       fy_q, fy_d;
    logic       match;
`ifdef GATE_BIST_ERRCNT_EN
    logic [2:0] err_q, err_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= 2'b00;
            cnt_q   <= 4'd0;
            pass_q  <= 1'b0;
            fv_q    <= 2'b00;
            fy_q    <= 1'b0;
`ifdef GATE_BIST_ERRCNT_EN
            err_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            fv_q    <= fv_d;
            fy_q    <= fy_d;
`ifdef GATE_BIST_ERRCNT_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        fv_d    = fv_q;
        fy_d    = fy_q;
`ifdef GATE_BIST_ERRCNT_EN
        err_d   = err_q;
`endif
        match   = (dut_y == TRUTH_TABLE[vec_q]);
        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d   = 2'b00;
                    cnt_d   = 4'd0;
                    pass_d  = 1'b0;
                    fv_d    = 2'b00;
                    fy_d    = 1'b0;
`ifdef GATE_BIST_ERRCNT_EN
                    err_d   = 3'd0;
`endif
                    state_d = APPLY;
                end
            end
            APPLY: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
            end
            SAMPLE: begin
`ifdef GATE_BIST_ERRCNT_EN
                // Every vector runs; only the first mismatch is recorded.
                if (!match) begin
                    err_d = err_q + 3'd1;
                    if (err_q == 3'd0) begin
                        fv_d = vec_q;
                        fy_d = dut_y;
                    end
                end
                if (vec_q == 2'd3) begin
                    pass_d  = match && (err_q == 3'd0);
                    state_d = FINISH;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = 4'd0;
                    state_d = APPLY;
                end
`else
                if (!match) begin
                    pass_d  = 1'b0;
                    fv_d    = vec_q;
                    fy_d    = dut_y;
                    state_d = FINISH;
                end else if (vec_q == 2'd3) begin
                    pass_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = 4'd0;
                    state_d = APPLY;
                end
`endif
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == APPLY) || (state_q == SAMPLE);
    assign done     = (state_q == FINISH);
    assign dut_a    = busy & vec_q[1];
    assign dut_b    = busy & vec_q[0];
    assign pass     = pass_q;
    assign fail_vec = fv_q;
    assign fail_y   = fy_q;
`ifdef GATE_BIST_ERRCNT_EN
    assign err_cnt  = err_q;
`endif

endmodule
